// File: rtl/instruction_fetch_pkg.sv
// Shared constants, state encoding and index helpers for the IF stage.
// Latency: n/a (types and functions only); backpressure: n/a.
package instruction_fetch_pkg;

  localparam int DEFAULT_PC_SIZE          = 32;
  localparam int DEFAULT_INSTRUCTION_SIZE = 32;
  localparam int DEFAULT_MEM_DEPTH        = 256;

  localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_LOAD = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_mem.sv
// Program store: word array, synchronous write, asynchronous (same-cycle) read.
// Latency: read 0 cycles, write lands on the clock edge; backpressure: none.
module instruction_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, program load pointer and LOAD/RUN/HALT control; emits {next_seq_pc, instruction}.
// Latency: fetch is combinational from o_pc; backpressure: i_stall and i_enable=0 hold the PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PC_SIZE          = DEFAULT_PC_SIZE,
  parameter int INSTRUCTION_SIZE = DEFAULT_INSTRUCTION_SIZE,
  parameter int MEM_DEPTH        = DEFAULT_MEM_DEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_stall,
  input  logic                        i_redirect,
  input  logic [PC_SIZE-1:0]          i_redirect_pc,
  input  logic                        i_load_valid,
  input  logic [INSTRUCTION_SIZE-1:0] i_load_data,
  input  logic                        i_load_clear,
  input  logic                        i_start,
  output logic [PC_SIZE-1:0]          o_pc,
  output logic [PC_SIZE-1:0]          o_next_seq_pc,
  output logic [INSTRUCTION_SIZE-1:0] o_instruction,
  output logic                        o_load_full,
  output logic                        o_halt
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [INSTRUCTION_SIZE-1:0] HALT_WORD = '1;
  localparam logic [INSTRUCTION_SIZE-1:0] NOP_WORD  = '0;
  localparam logic [AW:0]                 FULL_PTR  = (AW+1)'(MEM_DEPTH);

  if_state_e             state_q;
  logic [PC_SIZE-1:0]    pc_q;
  logic [PC_SIZE-1:0]    pc_plus4;
  logic                  halt_q;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;

  logic [AW-1:0]               rd_idx;
  logic [INSTRUCTION_SIZE-1:0] mem_rdata;
  logic [INSTRUCTION_SIZE-1:0] fetched;
  logic                        pc_oob;
  logic                        idx_unloaded;
  logic                        load_full;
  logic                        mem_we;

  assign pc_plus4 = pc_q + PC_SIZE'(4);
  assign rd_idx   = pc_q[AW+1:2];

  // Anything past the loaded program or past the store reads as HALT, so runaway fetch stops.
  assign pc_oob       = |pc_q[PC_SIZE-1:AW+2];
  assign idx_unloaded = ({1'b0, rd_idx} >= wr_ptr_q);
  assign fetched      = (pc_oob || idx_unloaded) ? HALT_WORD : mem_rdata;

  assign load_full = (wr_ptr_q == FULL_PTR);
  assign mem_we    = i_enable && !i_load_clear && (state_q == IF_LOAD)
                     && i_load_valid && !load_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (i_enable) begin
      if (i_load_clear) begin
        wr_ptr_d = '0;
      end else if (mem_we) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Control FSM; redirect outranks stall and HALT so a wrong-path HALT never stops fetch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IF_LOAD;
      pc_q    <= '0;
      halt_q  <= 1'b0;
    end else if (i_enable) begin
      if (i_load_clear) begin
        state_q <= IF_LOAD;
        pc_q    <= '0;
        halt_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IF_LOAD: begin
            pc_q <= '0;
            if (i_start) begin
              state_q <= IF_RUN;
            end
          end
          IF_RUN: begin
            if (i_redirect) begin
              pc_q <= i_redirect_pc;
            end else if (i_stall) begin
              pc_q <= pc_q;
            end else if (fetched == HALT_WORD) begin
              state_q <= IF_HALT;
              halt_q  <= 1'b1;
            end else begin
              pc_q <= pc_plus4;
            end
          end
          default: begin
            pc_q <= pc_q;
          end
        endcase
      end
    end
  end

  instruction_memory #(
    .DATA_WIDTH(INSTRUCTION_SIZE),
    .DEPTH     (MEM_DEPTH),
    .AW        (AW)
  ) u_mem (
    .i_clk  (i_clk),
    .i_we   (mem_we),
    .i_waddr(wr_ptr_q[AW-1:0]),
    .i_wdata(i_load_data),
    .i_raddr(rd_idx),
    .o_rdata(mem_rdata)
  );

  assign o_pc          = pc_q;
  assign o_next_seq_pc = pc_plus4;
  assign o_instruction = (state_q == IF_LOAD) ? NOP_WORD : fetched;
  assign o_load_full   = load_full;
  assign o_halt        = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: default-depth instance plus a MEM_DEPTH=4 instance on shared inputs.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic        lv;
  logic [31:0] ld;
  logic        lc;
  logic        st;

  logic [31:0] pc, nsp, ins;
  logic        full, halt;
  logic [31:0] pc4, nsp4, ins4;
  logic        full4, halt4;

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] W_A  = 32'h2001_0005;
  localparam logic [31:0] W_B  = 32'h2002_0007;
  localparam logic [31:0] W_C  = 32'h2003_0001;
  localparam logic [31:0] W_D  = 32'h2004_0002;
  localparam logic [31:0] W_E  = 32'h1234_5678;
  localparam logic [31:0] W_X  = 32'h2005_0009;
  localparam logic [31:0] W_Y  = 32'h2006_000B;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic [31:0] exp_pc   [4] = '{32'd0, 32'd4, 32'd8, 32'd8};
  logic [31:0] exp_nsp  [4] = '{32'd4, 32'd8, 32'd12, 32'd12};
  logic [31:0] exp_ins  [4] = '{W_A, W_B, HALT, HALT};
  logic        exp_halt [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  instruction_fetch dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall),
    .i_redirect(redir), .i_redirect_pc(redir_pc),
    .i_load_valid(lv), .i_load_data(ld), .i_load_clear(lc), .i_start(st),
    .o_pc(pc), .o_next_seq_pc(nsp), .o_instruction(ins),
    .o_load_full(full), .o_halt(halt)
  );

  instruction_fetch #(.MEM_DEPTH(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_stall(stall),
    .i_redirect(redir), .i_redirect_pc(redir_pc),
    .i_load_valid(lv), .i_load_data(ld), .i_load_clear(lc), .i_start(st),
    .o_pc(pc4), .o_next_seq_pc(nsp4), .o_instruction(ins4),
    .o_load_full(full4), .o_halt(halt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    lv = 1'b1;
    ld = w;
    tick();
    lv = 1'b0;
  endtask

  task automatic start_run();
    st = 1'b1;
    tick();
    st = 1'b0;
  endtask

  task automatic clear_prog();
    lc = 1'b1;
    tick();
    lc = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (pc !== 32'd0) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'd0); end
    checks++; if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt: got %b want 0", halt); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (ins !== 32'd0) begin fails++; $display("FAIL reset_ins: got %h want 0", ins); end
    checks++; if (full4 !== 1'b0) begin fails++; $display("FAIL reset_full4: got %b want 0", full4); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch();
    load_word(W_A);
    load_word(W_B);
    load_word(HALT);
    checks++; if (ins !== 32'd0) begin fails++; $display("FAIL load_nop: got %h want 0", ins); end
    start_run();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== exp_pc[i]) begin fails++; $display("FAIL basic_pc[%0d]: got %h want %h", i, pc, exp_pc[i]); end
      checks++; if (nsp !== exp_nsp[i]) begin fails++; $display("FAIL basic_nsp[%0d]: got %h want %h", i, nsp, exp_nsp[i]); end
      checks++; if (ins !== exp_ins[i]) begin fails++; $display("FAIL basic_ins[%0d]: got %h want %h", i, ins, exp_ins[i]); end
      checks++; if (halt !== exp_halt[i]) begin fails++; $display("FAIL basic_halt[%0d]: got %b want %b", i, halt, exp_halt[i]); end
      tick();
    end
  endtask

  task automatic test_stall();
    clear_prog();
    load_word(W_A);
    load_word(W_B);
    load_word(W_C);
    load_word(W_D);
    load_word(HALT);
    start_run();
    tick();
    tick();
    checks++; if (pc !== 32'd8) begin fails++; $display("FAIL stall_pre: got %h want %h", pc, 32'd8); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'd8) begin fails++; $display("FAIL stall_hold[%0d]: got %h want %h", i, pc, 32'd8); end
    end
    stall = 1'b0;
    tick();
    checks++; if (pc !== 32'd12) begin fails++; $display("FAIL stall_release: got %h want %h", pc, 32'd12); end
  endtask

  task automatic test_redirect();
    stall    = 1'b1;
    redir    = 1'b1;
    redir_pc = 32'h40;
    tick();
    stall = 1'b0;
    checks++; if (pc !== 32'h40) begin fails++; $display("FAIL redir_over_stall: got %h want %h", pc, 32'h40); end
    checks++; if (ins !== HALT) begin fails++; $display("FAIL redir_unloaded_ins: got %h want %h", ins, HALT); end
    redir_pc = 32'h0;
    tick();
    checks++; if (pc !== 32'h0) begin fails++; $display("FAIL redir_over_halt_pc: got %h want %h", pc, 32'h0); end
    checks++; if (halt !== 1'b0) begin fails++; $display("FAIL redir_over_halt_halt: got %b want 0", halt); end
    redir = 1'b0;
    tick();
    checks++; if (pc !== 32'd4 || ins !== W_B) begin fails++; $display("FAIL redir_resume: got pc %h ins %h want pc 4 ins %h", pc, ins, W_B); end
  endtask

  task automatic test_enable_and_reset();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'd4 || halt !== 1'b0 || ins !== W_B) begin fails++; $display("FAIL enable_hold[%0d]: got pc %h halt %b ins %h want pc 4 halt 0 ins %h", i, pc, halt, ins, W_B); end
    end
    en = 1'b1;
    tick();
    checks++; if (pc !== 32'd8) begin fails++; $display("FAIL enable_resume: got %h want %h", pc, 32'd8); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'd0) begin fails++; $display("FAIL async_reset_pc: got %h want 0", pc); end
    checks++; if (ins !== 32'd0) begin fails++; $display("FAIL async_reset_load_state: got ins %h want 0", ins); end
    checks++; if (nsp !== 32'd4) begin fails++; $display("FAIL async_reset_nsp: got %h want 4", nsp); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_depth_limit();
    load_word(W_A);
    load_word(W_B);
    load_word(W_C);
    checks++; if (full4 !== 1'b0) begin fails++; $display("FAIL full4_after3: got %b want 0", full4); end
    load_word(W_D);
    checks++; if (full4 !== 1'b1) begin fails++; $display("FAIL full4_after4: got %b want 1", full4); end
    load_word(W_E);
    checks++; if (full4 !== 1'b1) begin fails++; $display("FAIL full4_after5: got %b want 1", full4); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL full_deep_after5: got %b want 0", full); end
    start_run();
    checks++; if (pc4 !== 32'd0 || ins4 !== W_A) begin fails++; $display("FAIL depth_word0: got pc %h ins %h want pc 0 ins %h", pc4, ins4, W_A); end
    tick();
    tick();
    tick();
    checks++; if (pc4 !== 32'd12 || ins4 !== W_D) begin fails++; $display("FAIL depth_word3: got pc %h ins %h want pc c ins %h", pc4, ins4, W_D); end
    tick();
    checks++; if (pc4 !== 32'd16 || ins4 !== HALT || halt4 !== 1'b0) begin fails++; $display("FAIL depth_oob: got pc %h ins %h halt %b want pc 10 ins %h halt 0", pc4, ins4, halt4, HALT); end
    checks++; if (ins !== W_E) begin fails++; $display("FAIL deep_word4: got %h want %h", ins, W_E); end
    tick();
    checks++; if (pc4 !== 32'd16 || halt4 !== 1'b1) begin fails++; $display("FAIL depth_halt: got pc %h halt %b want pc 10 halt 1", pc4, halt4); end
  endtask

  task automatic test_clear_reload();
    tick();
    checks++; if (halt !== 1'b1 || pc !== 32'd20) begin fails++; $display("FAIL deep_halt: got pc %h halt %b want pc 14 halt 1", pc, halt); end
    clear_prog();
    checks++; if (halt !== 1'b0 || ins !== 32'd0 || pc !== 32'd0) begin fails++; $display("FAIL clear_state: got pc %h halt %b ins %h want 0 0 0", pc, halt, ins); end
    checks++; if (halt4 !== 1'b0 || full4 !== 1'b0) begin fails++; $display("FAIL clear_state4: got halt %b full %b want 0 0", halt4, full4); end
    load_word(W_X);
    load_word(W_Y);
    start_run();
    checks++; if (pc !== 32'd0 || ins !== W_X) begin fails++; $display("FAIL reload_w0: got pc %h ins %h want pc 0 ins %h", pc, ins, W_X); end
    tick();
    checks++; if (pc !== 32'd4 || ins !== W_Y) begin fails++; $display("FAIL reload_w1: got pc %h ins %h want pc 4 ins %h", pc, ins, W_Y); end
    tick();
    checks++; if (pc !== 32'd8 || ins !== HALT) begin fails++; $display("FAIL reload_end: got pc %h ins %h want pc 8 ins %h", pc, ins, HALT); end
    tick();
    checks++; if (halt !== 1'b1 || pc !== 32'd8) begin fails++; $display("FAIL reload_halt: got pc %h halt %b want pc 8 halt 1", pc, halt); end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    stall    = 1'b0;
    redir    = 1'b0;
    redir_pc = 32'd0;
    lv       = 1'b0;
    ld       = 32'd0;
    lc       = 1'b0;
    st       = 1'b0;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect();
    test_enable_and_reset();
    test_depth_limit();
    test_clear_reload();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
